// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer; define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_en,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_busy,
  output logic                          o_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q, head;
  logic          tx_q, push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif
  assign o_count = wr_q - rd_q;
  assign o_full  = o_count == (AW+1)'(FIFO_DEPTH);
  assign o_empty = o_count == '0;
  assign o_busy  = state_q != IDLE;
  assign o_tx    = tx_q;
  assign head    = mem_q[rd_q[AW-1:0]];
  assign bit_end = baud_q == '0;
  assign push    = i_wr_en && !o_full;
  // A pop at the end of STOP chains the next frame with no idle gap.
  assign pop     = !o_empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign wr_d    = push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = pop ? rd_q + 1'b1 : rd_q;
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem_q[wr_q[AW-1:0]] <= i_wr_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      baud_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (pop) begin
        state_q <= START;
        baud_q  <= BAUD_MAX;
        sh_q    <= head;
        tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end else if (state_q != IDLE) begin
        baud_q <= bit_end ? BAUD_MAX : baud_q - 1'b1;
        if (bit_end) begin
          case (state_q)
            START: begin
              state_q <= DATA;
              tx_q    <= sh_q[0];
              sh_q    <= sh_q >> 1;
            end
            DATA: begin
              idx_q <= idx_q + 1'b1;
              if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_q <= PARITY;
                tx_q    <= par_q;
`else
                state_q <= STOP;
                tx_q    <= 1'b1;
`endif
              end else begin
                tx_q <= sh_q[0];
                sh_q <= sh_q >> 1;
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
`endif
            default: begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          endcase
        end
      end
    end
  end
endmodule
